// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline boundary registers.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic       ALUSrc;
        logic       ALUSrc2;
        logic [2:0] ALUOp;
        logic       MemWE;
        logic       Mem2Reg;
        logic       RegWE;
        logic       Movz;
        logic       LDURB;
        logic       PC_Src;
        logic [3:0] xfer_size;
        logic [3:0] Movk;
        logic [5:0] shift;
    } idex_ctrl_t;

    typedef struct packed {
        logic       MemWE;
        logic       Mem2Reg;
        logic       RegWE;
        logic       LDURB;
        logic [3:0] xfer_size;
    } exmem_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// W-bit register with asynchronous active-high reset to RST_VAL.
module pipe_reg #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// IF/ID, ID/EX and EX/MEM boundary registers; pure storage, all stages load every cycle.
// Optional PIPE_FLUSH_EN adds ifid_flush to squash the IF/ID capture into a NOP bubble.
module pipeline_stage_regs
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned RA_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
`ifdef PIPE_FLUSH_EN
    input  logic               ifid_flush,
`endif
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [DATA_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [DATA_W-1:0]  ifid_pc,
    input  logic               id_ALUSrc,
    input  logic               id_ALUSrc2,
    input  logic [2:0]         id_ALUOp,
    input  logic               id_MemWE,
    input  logic               id_Mem2Reg,
    input  logic               id_RegWE,
    input  logic               id_Movz,
    input  logic               id_LDURB,
    input  logic               id_PC_Src,
    input  logic [3:0]         id_xfer_size,
    input  logic [3:0]         id_Movk,
    input  logic [5:0]         id_shift,
    input  logic [8:0]         id_DAddr9,
    input  logic [11:0]        id_Imm12,
    input  logic [15:0]        id_Imm16,
    input  logic [DATA_W-1:0]  id_rd1,
    input  logic [DATA_W-1:0]  id_rd2,
    input  logic [RA_W-1:0]    id_Rd,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic [DATA_W-1:0]  id_br_addr,
    output logic               idex_ALUSrc,
    output logic               idex_ALUSrc2,
    output logic [2:0]         idex_ALUOp,
    output logic               idex_MemWE,
    output logic               idex_Mem2Reg,
    output logic               idex_RegWE,
    output logic               idex_Movz,
    output logic               idex_LDURB,
    output logic               idex_PC_Src,
    output logic [3:0]         idex_xfer_size,
    output logic [3:0]         idex_Movk,
    output logic [5:0]         idex_shift,
    output logic [8:0]         idex_DAddr9,
    output logic [11:0]        idex_Imm12,
    output logic [15:0]        idex_Imm16,
    output logic [DATA_W-1:0]  idex_rd1,
    output logic [DATA_W-1:0]  idex_rd2,
    output logic [RA_W-1:0]    idex_Rd,
    output logic [INSTR_W-1:0] idex_instr,
    output logic [DATA_W-1:0]  idex_br_addr,
    input  logic               ex_MemWE,
    input  logic               ex_Mem2Reg,
    input  logic               ex_RegWE,
    input  logic               ex_LDURB,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic [DATA_W-1:0]  ex_rd2,
    input  logic [RA_W-1:0]    ex_Rd,
    input  logic [3:0]         ex_xfer_size,
    output logic               exmem_MemWE,
    output logic               exmem_Mem2Reg,
    output logic               exmem_RegWE,
    output logic               exmem_LDURB,
    output logic [DATA_W-1:0]  exmem_result,
    output logic [DATA_W-1:0]  exmem_rd2,
    output logic [RA_W-1:0]    exmem_Rd,
    output logic [3:0]         exmem_xfer_size
);

    localparam int unsigned IFID_W  = INSTR_W + DATA_W;
    localparam int unsigned IDEX_W  = $bits(idex_ctrl_t) + 9 + 12 + 16 + 3 * DATA_W + RA_W
                                      + INSTR_W;
    localparam int unsigned EXMEM_W = $bits(exmem_ctrl_t) + 2 * DATA_W + RA_W;

    // A reset bubble is a NOP at PC 0 with every write/branch control cleared.
    localparam logic [IFID_W-1:0] IFID_RST = {INSTR_W'(NOP_INSTR), {DATA_W{1'b0}}};

    logic [IFID_W-1:0]  w_ifid_d,  w_ifid_q;
    logic [IDEX_W-1:0]  w_idex_d,  w_idex_q;
    logic [EXMEM_W-1:0] w_exmem_d, w_exmem_q;
    idex_ctrl_t         w_idex_ctrl_d,  w_idex_ctrl_q;
    exmem_ctrl_t        w_exmem_ctrl_d, w_exmem_ctrl_q;

    // IF/ID
`ifdef PIPE_FLUSH_EN
    assign w_ifid_d = ifid_flush ? IFID_RST : {if_instr, if_pc};
`else
    assign w_ifid_d = {if_instr, if_pc};
`endif

    pipe_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_ifid_d),
        .o_q   (w_ifid_q)
    );

    assign {ifid_instr, ifid_pc} = w_ifid_q;

    // ID/EX
    assign w_idex_ctrl_d = '{
        ALUSrc:    id_ALUSrc,
        ALUSrc2:   id_ALUSrc2,
        ALUOp:     id_ALUOp,
        MemWE:     id_MemWE,
        Mem2Reg:   id_Mem2Reg,
        RegWE:     id_RegWE,
        Movz:      id_Movz,
        LDURB:     id_LDURB,
        PC_Src:    id_PC_Src,
        xfer_size: id_xfer_size,
        Movk:      id_Movk,
        shift:     id_shift
    };

    assign w_idex_d = {w_idex_ctrl_d, id_DAddr9, id_Imm12, id_Imm16, id_rd1, id_rd2, id_Rd,
                       id_instr, id_br_addr};

    pipe_reg #(.W(IDEX_W), .RST_VAL('0)) u_idex (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_idex_d),
        .o_q   (w_idex_q)
    );

    assign {w_idex_ctrl_q, idex_DAddr9, idex_Imm12, idex_Imm16, idex_rd1, idex_rd2, idex_Rd,
            idex_instr, idex_br_addr} = w_idex_q;

    assign idex_ALUSrc    = w_idex_ctrl_q.ALUSrc;
    assign idex_ALUSrc2   = w_idex_ctrl_q.ALUSrc2;
    assign idex_ALUOp     = w_idex_ctrl_q.ALUOp;
    assign idex_MemWE     = w_idex_ctrl_q.MemWE;
    assign idex_Mem2Reg   = w_idex_ctrl_q.Mem2Reg;
    assign idex_RegWE     = w_idex_ctrl_q.RegWE;
    assign idex_Movz      = w_idex_ctrl_q.Movz;
    assign idex_LDURB     = w_idex_ctrl_q.LDURB;
    assign idex_PC_Src    = w_idex_ctrl_q.PC_Src;
    assign idex_xfer_size = w_idex_ctrl_q.xfer_size;
    assign idex_Movk      = w_idex_ctrl_q.Movk;
    assign idex_shift     = w_idex_ctrl_q.shift;

    // EX/MEM
    assign w_exmem_ctrl_d = '{
        MemWE:     ex_MemWE,
        Mem2Reg:   ex_Mem2Reg,
        RegWE:     ex_RegWE,
        LDURB:     ex_LDURB,
        xfer_size: ex_xfer_size
    };

    assign w_exmem_d = {w_exmem_ctrl_d, ex_result, ex_rd2, ex_Rd};

    pipe_reg #(.W(EXMEM_W), .RST_VAL('0)) u_exmem (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_exmem_d),
        .o_q   (w_exmem_q)
    );

    assign {w_exmem_ctrl_q, exmem_result, exmem_rd2, exmem_Rd} = w_exmem_q;

    assign exmem_MemWE     = w_exmem_ctrl_q.MemWE;
    assign exmem_Mem2Reg   = w_exmem_ctrl_q.Mem2Reg;
    assign exmem_RegWE     = w_exmem_ctrl_q.RegWE;
    assign exmem_LDURB     = w_exmem_ctrl_q.LDURB;
    assign exmem_xfer_size = w_exmem_ctrl_q.xfer_size;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Bench for pipeline_stage_regs: directed vectors, reset/flush sequences, random vs. model.
module tb_pipeline_stage_regs;

    // Every DUT input, in one record; the expected outputs use the same record.
    typedef struct packed {
        logic [31:0] if_instr;
        logic [63:0] if_pc;
        logic        ALUSrc;
        logic        ALUSrc2;
        logic [2:0]  ALUOp;
        logic        MemWE;
        logic        Mem2Reg;
        logic        RegWE;
        logic        Movz;
        logic        LDURB;
        logic        PC_Src;
        logic [3:0]  xfer_size;
        logic [3:0]  Movk;
        logic [5:0]  shift;
        logic [8:0]  DAddr9;
        logic [11:0] Imm12;
        logic [15:0] Imm16;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [4:0]  Rd;
        logic [31:0] instr;
        logic [63:0] br_addr;
        logic        ex_MemWE;
        logic        ex_Mem2Reg;
        logic        ex_RegWE;
        logic        ex_LDURB;
        logic [63:0] ex_result;
        logic [63:0] ex_rd2;
        logic [4:0]  ex_Rd;
        logic [3:0]  ex_xfer_size;
    } sig_t;

    localparam int SW = $bits(sig_t);

    typedef struct {
        sig_t        stim;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic [63:0] e_rd1;
        logic [15:0] e_imm16;
        logic [3:0]  e_movk;
        logic [4:0]  e_rd;
        logic [63:0] e_result;
        logic        e_memwe;
        logic [3:0]  e_xfer;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    sig_t in_v;
    sig_t out_v;
`ifdef PIPE_FLUSH_EN
    logic ifid_flush;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic        idex_ALUSrc, idex_ALUSrc2, idex_MemWE, idex_Mem2Reg, idex_RegWE;
    logic        idex_Movz, idex_LDURB, idex_PC_Src;
    logic [2:0]  idex_ALUOp;
    logic [3:0]  idex_xfer_size, idex_Movk;
    logic [5:0]  idex_shift;
    logic [8:0]  idex_DAddr9;
    logic [11:0] idex_Imm12;
    logic [15:0] idex_Imm16;
    logic [63:0] idex_rd1, idex_rd2, idex_br_addr;
    logic [4:0]  idex_Rd;
    logic [31:0] idex_instr;
    logic        exmem_MemWE, exmem_Mem2Reg, exmem_RegWE, exmem_LDURB;
    logic [63:0] exmem_result, exmem_rd2;
    logic [4:0]  exmem_Rd;
    logic [3:0]  exmem_xfer_size;

    always #5 clk = ~clk;

    pipeline_stage_regs dut (
        .clk             (clk),
        .reset           (reset),
`ifdef PIPE_FLUSH_EN
        .ifid_flush      (ifid_flush),
`endif
        .if_instr        (in_v.if_instr),
        .if_pc           (in_v.if_pc),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .id_ALUSrc       (in_v.ALUSrc),
        .id_ALUSrc2      (in_v.ALUSrc2),
        .id_ALUOp        (in_v.ALUOp),
        .id_MemWE        (in_v.MemWE),
        .id_Mem2Reg      (in_v.Mem2Reg),
        .id_RegWE        (in_v.RegWE),
        .id_Movz         (in_v.Movz),
        .id_LDURB        (in_v.LDURB),
        .id_PC_Src       (in_v.PC_Src),
        .id_xfer_size    (in_v.xfer_size),
        .id_Movk         (in_v.Movk),
        .id_shift        (in_v.shift),
        .id_DAddr9       (in_v.DAddr9),
        .id_Imm12        (in_v.Imm12),
        .id_Imm16        (in_v.Imm16),
        .id_rd1          (in_v.rd1),
        .id_rd2          (in_v.rd2),
        .id_Rd           (in_v.Rd),
        .id_instr        (in_v.instr),
        .id_br_addr      (in_v.br_addr),
        .idex_ALUSrc     (idex_ALUSrc),
        .idex_ALUSrc2    (idex_ALUSrc2),
        .idex_ALUOp      (idex_ALUOp),
        .idex_MemWE      (idex_MemWE),
        .idex_Mem2Reg    (idex_Mem2Reg),
        .idex_RegWE      (idex_RegWE),
        .idex_Movz       (idex_Movz),
        .idex_LDURB      (idex_LDURB),
        .idex_PC_Src     (idex_PC_Src),
        .idex_xfer_size  (idex_xfer_size),
        .idex_Movk       (idex_Movk),
        .idex_shift      (idex_shift),
        .idex_DAddr9     (idex_DAddr9),
        .idex_Imm12      (idex_Imm12),
        .idex_Imm16      (idex_Imm16),
        .idex_rd1        (idex_rd1),
        .idex_rd2        (idex_rd2),
        .idex_Rd         (idex_Rd),
        .idex_instr      (idex_instr),
        .idex_br_addr    (idex_br_addr),
        .ex_MemWE        (in_v.ex_MemWE),
        .ex_Mem2Reg      (in_v.ex_Mem2Reg),
        .ex_RegWE        (in_v.ex_RegWE),
        .ex_LDURB        (in_v.ex_LDURB),
        .ex_result       (in_v.ex_result),
        .ex_rd2          (in_v.ex_rd2),
        .ex_Rd           (in_v.ex_Rd),
        .ex_xfer_size    (in_v.ex_xfer_size),
        .exmem_MemWE     (exmem_MemWE),
        .exmem_Mem2Reg   (exmem_Mem2Reg),
        .exmem_RegWE     (exmem_RegWE),
        .exmem_LDURB     (exmem_LDURB),
        .exmem_result    (exmem_result),
        .exmem_rd2       (exmem_rd2),
        .exmem_Rd        (exmem_Rd),
        .exmem_xfer_size (exmem_xfer_size)
    );

    always_comb begin
        out_v              = '0;
        out_v.if_instr     = ifid_instr;
        out_v.if_pc        = ifid_pc;
        out_v.ALUSrc       = idex_ALUSrc;
        out_v.ALUSrc2      = idex_ALUSrc2;
        out_v.ALUOp        = idex_ALUOp;
        out_v.MemWE        = idex_MemWE;
        out_v.Mem2Reg      = idex_Mem2Reg;
        out_v.RegWE        = idex_RegWE;
        out_v.Movz         = idex_Movz;
        out_v.LDURB        = idex_LDURB;
        out_v.PC_Src       = idex_PC_Src;
        out_v.xfer_size    = idex_xfer_size;
        out_v.Movk         = idex_Movk;
        out_v.shift        = idex_shift;
        out_v.DAddr9       = idex_DAddr9;
        out_v.Imm12        = idex_Imm12;
        out_v.Imm16        = idex_Imm16;
        out_v.rd1          = idex_rd1;
        out_v.rd2          = idex_rd2;
        out_v.Rd           = idex_Rd;
        out_v.instr        = idex_instr;
        out_v.br_addr      = idex_br_addr;
        out_v.ex_MemWE     = exmem_MemWE;
        out_v.ex_Mem2Reg   = exmem_Mem2Reg;
        out_v.ex_RegWE     = exmem_RegWE;
        out_v.ex_LDURB     = exmem_LDURB;
        out_v.ex_result    = exmem_result;
        out_v.ex_rd2       = exmem_rd2;
        out_v.ex_Rd        = exmem_Rd;
        out_v.ex_xfer_size = exmem_xfer_size;
    end

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic sig_t rand_sig();
        logic [SW-1:0] t;
        for (int i = 0; i < SW; i++) t[i] = 1'($urandom_range(0, 1));
        return sig_t'(t);
    endfunction

    // Model: after an edge every output equals the input present at that edge,
    // or zero if reset was high; a flush zeroes only the IF/ID pair.
    task automatic step(input string nm);
        sig_t e;
        e = reset ? '0 : in_v;
`ifdef PIPE_FLUSH_EN
        if (ifid_flush) begin
            e.if_instr = '0;
            e.if_pc    = '0;
        end
`endif
        @(posedge clk);
        #1;
        chk(nm, out_v, e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[3];
        sig_t z;
        z = '0;

        vecs[0] = '{stim: z, e_instr: 32'h91000421, e_pc: 64'h40, e_rd1: 64'h0, e_imm16: 16'h0,
                    e_movk: 4'h0, e_rd: 5'd0, e_result: 64'h0, e_memwe: 1'b0, e_xfer: 4'd0};
        vecs[0].stim.if_instr = 32'h91000421;
        vecs[0].stim.if_pc    = 64'h40;

        vecs[1] = '{stim: z, e_instr: 32'h0, e_pc: 64'h0, e_rd1: 64'hDEAD_BEEF,
                    e_imm16: 16'hABCD, e_movk: 4'b0100, e_rd: 5'd7, e_result: 64'h0,
                    e_memwe: 1'b0, e_xfer: 4'd0};
        vecs[1].stim.rd1   = 64'hDEAD_BEEF;
        vecs[1].stim.Imm16 = 16'hABCD;
        vecs[1].stim.Movk  = 4'b0100;
        vecs[1].stim.Rd    = 5'd7;

        vecs[2] = '{stim: z, e_instr: 32'h0, e_pc: 64'h0, e_rd1: 64'h0, e_imm16: 16'h0,
                    e_movk: 4'h0, e_rd: 5'd0, e_result: 64'h100, e_memwe: 1'b1, e_xfer: 4'd8};
        vecs[2].stim.ex_result    = 64'h100;
        vecs[2].stim.ex_MemWE     = 1'b1;
        vecs[2].stim.ex_xfer_size = 4'd8;

        reset = 1'b1;
        in_v  = rand_sig();
`ifdef PIPE_FLUSH_EN
        ifid_flush = 1'b0;
`endif
        #2;
        chk("reset_state", out_v, '0);
        reset = 1'b0;

        // Directed vectors
        for (int v = 0; v < 3; v++) begin
            in_v = vecs[v].stim;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ifid_instr", v), SW'(ifid_instr), SW'(vecs[v].e_instr));
            chk($sformatf("v%0d_ifid_pc", v), SW'(ifid_pc), SW'(vecs[v].e_pc));
            chk($sformatf("v%0d_idex_rd1", v), SW'(idex_rd1), SW'(vecs[v].e_rd1));
            chk($sformatf("v%0d_idex_Imm16", v), SW'(idex_Imm16), SW'(vecs[v].e_imm16));
            chk($sformatf("v%0d_idex_Movk", v), SW'(idex_Movk), SW'(vecs[v].e_movk));
            chk($sformatf("v%0d_idex_Rd", v), SW'(idex_Rd), SW'(vecs[v].e_rd));
            chk($sformatf("v%0d_exmem_result", v), SW'(exmem_result), SW'(vecs[v].e_result));
            chk($sformatf("v%0d_exmem_MemWE", v), SW'(exmem_MemWE), SW'(vecs[v].e_memwe));
            chk($sformatf("v%0d_exmem_xfer", v), SW'(exmem_xfer_size), SW'(vecs[v].e_xfer));
            chk($sformatf("v%0d_full", v), out_v, vecs[v].stim);
        end

        // ID/EX holds between edges even when inputs move
        in_v = vecs[1].stim;
        @(posedge clk);
        #1;
        in_v = rand_sig();
        #3;
        chk("hold_idex_rd1", SW'(idex_rd1), SW'(64'hDEAD_BEEF));
        chk("hold_idex_Imm16", SW'(idex_Imm16), SW'(16'hABCD));
        chk("hold_idex_Movk", SW'(idex_Movk), SW'(4'b0100));
        chk("hold_idex_Rd", SW'(idex_Rd), SW'(5'd7));
        step("hold_next_edge");

        // Asynchronous reset mid-stream, then release without an edge
        in_v = rand_sig();
        in_v.ex_MemWE = 1'b1;
        step("pre_reset_load");
        reset = 1'b1;
        #1;
        chk("async_reset_all", out_v, '0);
        chk("async_reset_exmem_MemWE", SW'(exmem_MemWE), SW'(1'b0));
        in_v = rand_sig();
        step("reset_held_edge");
        reset = 1'b0;
        #1;
        chk("release_no_capture", out_v, '0);
        step("resume_after_reset");

`ifdef PIPE_FLUSH_EN
        in_v          = rand_sig();
        in_v.if_instr = 32'hB400_0040;
        ifid_flush    = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_ifid_instr", SW'(ifid_instr), SW'(32'h0));
        chk("flush_ifid_pc", SW'(ifid_pc), SW'(64'h0));
        chk("flush_idex_rd1", SW'(idex_rd1), SW'(in_v.rd1));
        chk("flush_exmem_result", SW'(exmem_result), SW'(in_v.ex_result));
        ifid_flush = 1'b0;
        in_v = rand_sig();
        step("pre_flush_reset");
        ifid_flush = 1'b1;
        reset      = 1'b1;
        #1;
        chk("flush_and_reset_async", out_v, '0);
        step("flush_and_reset_edge");
        reset      = 1'b0;
        ifid_flush = 1'b0;
`endif

        // Random traffic against the model
        for (int c = 0; c < 1000; c++) begin
            in_v = rand_sig();
`ifdef PIPE_FLUSH_EN
            ifid_flush = ($urandom_range(0, 7) == 0);
`endif
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
